// File: rtl/ram_cycle_ctl_if.sv
// Signal bundle between the FSB chip-select decode and the DRAM cycle sequencer,
// plus the sequencer's debug taps (current FSM state and refresh debt).
//
// Handshake: a request is ASActive && RAMCS sampled on a rising CLK edge while
// the sequencer is IDLE (or latched by it when refresh preempts). There is no
// request-side ready; RAMReady is a one-cycle pulse telling the FSB it may end
// the cycle, and the cycle is closed by ASInactive sampled high while in HOLD.
interface ram_cycle_ctl_if;
  logic       RAMCS;
  logic       ASActive;
  logic       ASInactive;
  logic       nWE;
  logic       nUDS;
  logic       nLDS;
  logic       nRAS;
  logic       nCAS;
  logic       RAMuxCol;
  logic       nRAMUWE;
  logic       nRAMLWE;
  logic       RAMReady;
  logic       RefBusy;
  logic [2:0] dbg_state;
  logic [1:0] dbg_pending;

  modport slave (
    input  RAMCS, ASActive, ASInactive, nWE, nUDS, nLDS,
    output nRAS, nCAS, RAMuxCol, nRAMUWE, nRAMLWE, RAMReady, RefBusy,
           dbg_state, dbg_pending
  );

  modport master (
    output RAMCS, ASActive, ASInactive, nWE, nUDS, nLDS,
    input  nRAS, nCAS, RAMuxCol, nRAMUWE, nRAMLWE, RAMReady, RefBusy,
           dbg_state, dbg_pending
  );
endinterface

// File: rtl/ram_cycle_ctl.sv
// DRAM cycle sequencer for the FSB RAM window: RAS/CAS/mux/WE timing, a one-cycle
// RAMReady, and CAS-before-RAS refresh driven by a free-running timer.
module ram_cycle_ctl #(
  parameter int RefPeriod = 16,
  parameter int RefUrgent = 2,
  parameter int RefRASCyc = 2,
  parameter int PreCyc    = 2
) (
  input  logic           CLK,
  input  logic           nRES,
  ram_cycle_ctl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RAS  = 3'd1;
  localparam logic [2:0] S_CAS  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_PRE  = 3'd4;
  localparam logic [2:0] S_RCAS = 3'd5;
  localparam logic [2:0] S_RRAS = 3'd6;
  localparam logic [2:0] S_RPRE = 3'd7;

  localparam int              TW         = (RefPeriod > 1) ? $clog2(RefPeriod) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(RefPeriod - 1);
  localparam logic [7:0]      RRAS_LAST  = 8'(RefRASCyc - 1);
  localparam logic [7:0]      PRE_LAST   = 8'(PreCyc - 1);
  localparam logic [2:0]      URGENT     = 3'(RefUrgent);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [7:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_pending;
  logic          r_cpu_wait;

  logic r_nras, r_ncas, r_mux, r_nuwe, r_nlwe, r_ready, r_refbusy;
  logic w_nras, w_ncas, w_mux, w_nuwe, w_nlwe, w_ready, w_refbusy;

  logic w_start;
  logic w_urgent;
  logic w_tc;
  logic w_dec;

  assign w_start  = bus.ASActive && bus.RAMCS;
  assign w_urgent = ({1'b0, r_pending} >= URGENT);
  assign w_tc     = (r_timer == TIMER_LAST);
  // Debt is paid when the RAS-low phase of a refresh ends, not when the sequence starts.
  assign w_dec    = (r_state == S_RRAS) && (r_cnt == RRAS_LAST) && (r_pending != 2'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = w_urgent ? S_RCAS : S_RAS;
        end else if (r_pending != 2'd0) begin
          w_next = S_RCAS;
        end
      end
      S_RAS:  w_next = S_CAS;
      S_CAS:  w_next = S_HOLD;
      S_HOLD: begin
        if (bus.ASInactive) w_next = S_PRE;
      end
      S_PRE: begin
        if (r_cnt == PRE_LAST) w_next = r_cpu_wait ? S_RAS : S_IDLE;
      end
      S_RCAS: w_next = S_RRAS;
      S_RRAS: begin
        if (r_cnt == RRAS_LAST) w_next = S_RPRE;
      end
      S_RPRE: begin
        if (r_cnt == PRE_LAST) w_next = r_cpu_wait ? S_RAS : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe is a plain flop.
  always_comb begin
    w_nras    = 1'b1;
    w_ncas    = 1'b1;
    w_mux     = 1'b0;
    w_nuwe    = 1'b1;
    w_nlwe    = 1'b1;
    w_ready   = 1'b0;
    w_refbusy = 1'b0;
    case (w_next)
      S_RAS: begin
        w_nras = 1'b0;
      end
      S_CAS: begin
        w_nras  = 1'b0;
        w_ncas  = 1'b0;
        w_mux   = 1'b1;
        w_ready = 1'b1;
        if (!bus.nWE) begin
          w_nuwe = bus.nUDS;
          w_nlwe = bus.nLDS;
        end
      end
      S_HOLD: begin
        w_nras = 1'b0;
        w_ncas = 1'b0;
        w_mux  = 1'b1;
        w_nuwe = r_nuwe;
        w_nlwe = r_nlwe;
      end
      S_RCAS: begin
        w_ncas    = 1'b0;
        w_refbusy = 1'b1;
      end
      S_RRAS: begin
        w_nras    = 1'b0;
        w_ncas    = 1'b0;
        w_refbusy = 1'b1;
      end
      S_RPRE: begin
        w_refbusy = 1'b1;
      end
      default: begin
        w_nras = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_timer    <= '0;
      r_pending  <= 2'd0;
      r_cpu_wait <= 1'b0;
      r_nras     <= 1'b1;
      r_ncas     <= 1'b1;
      r_mux      <= 1'b0;
      r_nuwe     <= 1'b1;
      r_nlwe     <= 1'b1;
      r_ready    <= 1'b0;
      r_refbusy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state) ? r_cnt + 8'd1 : 8'd0;
      r_timer <= w_tc ? '0 : r_timer + TW'(1);

      if (w_tc && !w_dec) begin
        if (r_pending != 2'd3) r_pending <= r_pending + 2'd1;
      end else if (w_dec && !w_tc) begin
        r_pending <= r_pending - 2'd1;
      end

      // A CPU start that loses to urgent refresh is remembered and served after RPRE.
      if (r_state == S_IDLE && w_start && w_urgent) begin
        r_cpu_wait <= 1'b1;
      end else if (w_next == S_RAS) begin
        r_cpu_wait <= 1'b0;
      end

      r_nras    <= w_nras;
      r_ncas    <= w_ncas;
      r_mux     <= w_mux;
      r_nuwe    <= w_nuwe;
      r_nlwe    <= w_nlwe;
      r_ready   <= w_ready;
      r_refbusy <= w_refbusy;
    end
  end

  assign bus.nRAS        = r_nras;
  assign bus.nCAS        = r_ncas;
  assign bus.RAMuxCol    = r_mux;
  assign bus.nRAMUWE     = r_nuwe;
  assign bus.nRAMLWE     = r_nlwe;
  assign bus.RAMReady    = r_ready;
  assign bus.RefBusy     = r_refbusy;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_pending = r_pending;

endmodule

// File: tb/tb_ram_cycle_ctl.sv
// Bench for ram_cycle_ctl: a waveform-schedule model predicts every output vector
// and the refresh debt each cycle; scenario tasks add timing checks from the datasheet rules.
module tb_ram_cycle_ctl;

  localparam int REF_PERIOD = 16;
  localparam int REF_URGENT = 2;
  localparam int REF_RAS    = 2;
  localparam int PRE_CYC    = 2;

  // Output vector order: {nRAS, nCAS, RAMuxCol, nRAMUWE, nRAMLWE, RAMReady, RefBusy}
  localparam logic [6:0] V_IDLE = 7'b1101100;
  localparam logic [6:0] V_RAS  = 7'b0101100;
  localparam logic [6:0] V_CAS  = 7'b0011110;
  localparam logic [6:0] V_HOLD = 7'b0011100;
  localparam logic [6:0] V_RCAS = 7'b1001101;
  localparam logic [6:0] V_RRAS = 7'b0001101;
  localparam logic [6:0] V_RPRE = 7'b1101101;

  typedef struct packed {
    logic       dec;
    logic       cas;
    logic       hold;
    logic [6:0] o;
  } ent_t;

  logic CLK  = 1'b0;
  logic nRES = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  ram_cycle_ctl_if bus();

  ram_cycle_ctl #(
    .RefPeriod(REF_PERIOD),
    .RefUrgent(REF_URGENT),
    .RefRASCyc(REF_RAS),
    .PreCyc   (PRE_CYC)
  ) dut (
    .CLK (CLK),
    .nRES(nRES),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  ent_t m_q[$];
  ent_t m_cur;
  bit   m_idle;
  int   m_timer;
  int   m_pend;
  logic m_uwe;
  logic m_lwe;

  function automatic ent_t mk(logic [6:0] o, logic dec, logic cas, logic hold);
    ent_t e;
    e.o = o; e.dec = dec; e.cas = cas; e.hold = hold;
    return e;
  endfunction

  function automatic logic [6:0] dut_vec();
    return {bus.nRAS, bus.nCAS, bus.RAMuxCol, bus.nRAMUWE, bus.nRAMLWE, bus.RAMReady, bus.RefBusy};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur   = mk(V_IDLE, 1'b0, 1'b0, 1'b0);
    m_idle  = 1'b1;
    m_timer = 0;
    m_pend  = 0;
    m_uwe   = 1'b1;
    m_lwe   = 1'b1;
  endtask

  task automatic push_refresh();
    m_q.push_back(mk(V_RCAS, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < REF_RAS; i++) m_q.push_back(mk(V_RRAS, (i == REF_RAS - 1), 1'b0, 1'b0));
    for (int i = 0; i < PRE_CYC; i++) m_q.push_back(mk(V_RPRE, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_cpu();
    m_q.push_back(mk(V_RAS, 1'b0, 1'b0, 1'b0));
    m_q.push_back(mk(V_CAS, 1'b0, 1'b1, 1'b0));
    m_q.push_back(mk(V_HOLD, 1'b0, 1'b0, 1'b1));
  endtask

  // Advance the model by one rising edge using the inputs presented in the ending cycle.
  task automatic model_step();
    int   old_pend;
    logic tc;
    logic start;
    old_pend = m_pend;
    tc       = (m_timer == REF_PERIOD - 1);
    if (tc && !m_cur.dec) begin
      if (m_pend < 3) m_pend++;
    end else if (m_cur.dec && !tc) begin
      m_pend--;
    end
    m_timer = (m_timer + 1) % REF_PERIOD;
    start   = bus.ASActive && bus.RAMCS;

    if (m_cur.hold && !bus.ASInactive) return;
    if (m_cur.hold) begin
      for (int i = 0; i < PRE_CYC; i++) m_q.push_back(mk(V_IDLE, 1'b0, 1'b0, 1'b0));
    end
    if (m_idle) begin
      if (start && old_pend >= REF_URGENT) begin
        push_refresh();
        push_cpu();
      end else if (start) begin
        push_cpu();
      end else if (old_pend > 0) begin
        push_refresh();
      end
    end
    if (m_q.size() > 0) begin
      m_cur  = m_q.pop_front();
      m_idle = 1'b0;
      if (m_cur.cas) begin
        m_uwe = bus.nWE ? 1'b1 : bus.nUDS;
        m_lwe = bus.nWE ? 1'b1 : bus.nLDS;
      end
      if (m_cur.cas || m_cur.hold) m_cur.o[3:2] = {m_uwe, m_lwe};
    end else begin
      m_cur  = mk(V_IDLE, 1'b0, 1'b0, 1'b0);
      m_idle = 1'b1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.RAMCS      = 1'b0;
    bus.ASActive   = 1'b0;
    bus.ASInactive = 1'b1;
    bus.nWE        = 1'b1;
    bus.nUDS       = 1'b1;
    bus.nLDS       = 1'b1;
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (nRES) model_step();
    else      model_reset();
    @(negedge CLK);
  endtask

  task automatic wait_model_idle(input int max_cyc, input bit need_zero);
    int c;
    c = 0;
    while (!(m_idle && (!need_zero || m_pend == 0)) && c < max_cyc) begin
      cycle();
      c++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    nRES = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_total++;
      if (dut_vec() !== V_IDLE || bus.dbg_pending !== 2'd0)
        $display("FAIL reset_hold c%0d: got %b/p%0d want %b/p0", c, dut_vec(), bus.dbg_pending, V_IDLE);
      else n_pass++;
    end
    model_reset();
    nRES = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL reset_release c%0d: got %b/p%0d want %b/p%0d", c, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
    end
  endtask

  task automatic test_read();
    int ready_at;
    ready_at = -1;
    bus.ASActive = 1'b1; bus.RAMCS = 1'b1; bus.nWE = 1'b1;
    bus.nUDS = 1'b0; bus.nLDS = 1'b0; bus.ASInactive = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      bus.ASActive = 1'b0;
      if (c == 3) bus.ASInactive = 1'b1;
      if (bus.RAMReady === 1'b1 && ready_at < 0) ready_at = c;
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL read c%0d: got %b/p%0d want %b/p%0d", c, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if (bus.nRAS !== 1'b0 || bus.nCAS !== 1'b1 || bus.RAMuxCol !== 1'b0)
          $display("FAIL read_row: got nRAS=%b nCAS=%b mux=%b want 0 1 0", bus.nRAS, bus.nCAS, bus.RAMuxCol);
        else n_pass++;
      end
      if (c == 2) begin
        n_total++;
        if (bus.nCAS !== 1'b0 || bus.RAMuxCol !== 1'b1 || bus.nRAMUWE !== 1'b1 || bus.nRAMLWE !== 1'b1)
          $display("FAIL read_col: got nCAS=%b mux=%b uwe=%b lwe=%b want 0 1 1 1",
                   bus.nCAS, bus.RAMuxCol, bus.nRAMUWE, bus.nRAMLWE);
        else n_pass++;
      end
    end
    n_total++;
    if (ready_at !== 2) $display("FAIL read_latency: got %0d want 2", ready_at);
    else n_pass++;
    drive_idle();
  endtask

  task automatic test_write();
    logic [6:0] exp_tab [1:7];
    exp_tab[1] = V_RAS;
    exp_tab[2] = 7'b0010110;
    exp_tab[3] = 7'b0010100;
    exp_tab[4] = 7'b0010100;
    exp_tab[5] = V_IDLE;
    exp_tab[6] = V_IDLE;
    exp_tab[7] = V_IDLE;
    wait_model_idle(40, 1'b0);
    bus.ASActive = 1'b1; bus.RAMCS = 1'b1; bus.nWE = 1'b0;
    bus.nUDS = 1'b0; bus.nLDS = 1'b1; bus.ASInactive = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      cycle();
      bus.ASActive = 1'b0;
      if (c == 4) bus.ASInactive = 1'b1;
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL write c%0d: got %b/p%0d want %b/p%0d", c, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
      n_total++;
      if (dut_vec() !== exp_tab[c])
        $display("FAIL write_timing c%0d: got %b want %b", c, dut_vec(), exp_tab[c]);
      else n_pass++;
    end
    drive_idle();
  endtask

  task automatic test_refresh_idle();
    logic [6:0] v [0:39];
    int first;
    int run;
    drive_idle();
    wait_model_idle(80, 1'b1);
    first = -1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      v[c] = dut_vec();
      if (first < 0 && v[c][0] === 1'b1) first = c;
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL refresh_idle c%0d: got %b/p%0d want %b/p%0d", c, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
    end
    n_total++;
    if (first < 0 || first > 30) begin
      $display("FAIL refresh_seen: got first RefBusy at %0d want within 0..30", first);
    end else begin
      run = 0;
      while (first + run < 40 && v[first + run][0] === 1'b1) run++;
      if (run != 5 || v[first][6] !== 1'b1 || v[first][5] !== 1'b0 ||
          v[first+1][6] !== 1'b0 || v[first+2][6] !== 1'b0 || v[first+3][6] !== 1'b1)
        $display("FAIL refresh_shape: busy run %0d want 5, vecs %b %b %b %b",
                 run, v[first], v[first+1], v[first+2], v[first+3]);
      else n_pass++;
    end
  endtask

  task automatic test_urgent();
    int c;
    drive_idle();
    wait_model_idle(40, 1'b0);
    bus.ASActive = 1'b1; bus.RAMCS = 1'b1; bus.nWE = 1'b1; bus.ASInactive = 1'b0;
    c = 0;
    while (!(m_cur.hold && m_pend >= REF_URGENT) && c < 80) begin
      cycle();
      bus.ASActive = 1'b0;
      c++;
    end
    bus.ASInactive = 1'b1;
    wait_model_idle(10, 1'b0);
    n_total++;
    if (!m_idle || m_pend < REF_URGENT) begin
      $display("FAIL urgent_setup: got idle=%0d pend=%0d want idle with pend>=2", m_idle, m_pend);
    end else begin
      n_pass++;
      bus.ASActive = 1'b1; bus.RAMCS = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        cycle();
        bus.ASActive = 1'b0;
        n_total++;
        if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
          $display("FAIL urgent c%0d: got %b/p%0d want %b/p%0d", k, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
        else n_pass++;
        if (k <= 5) begin
          n_total++;
          if (bus.RefBusy !== 1'b1 || bus.RAMReady !== 1'b0)
            $display("FAIL urgent_refresh_first c%0d: got busy=%b ready=%b want 1 0", k, bus.RefBusy, bus.RAMReady);
          else n_pass++;
        end
        if (k == 6) begin
          n_total++;
          if (bus.nRAS !== 1'b0 || bus.RefBusy !== 1'b0 || bus.nCAS !== 1'b1)
            $display("FAIL urgent_ras: got nRAS=%b busy=%b nCAS=%b want 0 0 1", bus.nRAS, bus.RefBusy, bus.nCAS);
          else n_pass++;
        end
        if (k == 7) begin
          n_total++;
          if (bus.RAMReady !== 1'b1) $display("FAIL urgent_ready: got %b want 1", bus.RAMReady);
          else n_pass++;
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_saturate();
    int  refreshes;
    int  c;
    logic prev_busy;
    drive_idle();
    wait_model_idle(40, 1'b0);
    bus.ASActive = 1'b1; bus.RAMCS = 1'b1; bus.nWE = 1'b1; bus.ASInactive = 1'b0;
    for (int k = 0; k < 63; k++) begin
      cycle();
      bus.ASActive = 1'b0;
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL saturate_hold c%0d: got %b/p%0d want %b/p%0d", k, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
    end
    n_total++;
    if (bus.dbg_pending !== 2'd3) $display("FAIL saturate_level: got %0d want 3", bus.dbg_pending);
    else n_pass++;
    bus.ASInactive = 1'b1;
    refreshes = 0;
    prev_busy = 1'b0;
    c = 0;
    while (c < 4 || !(m_idle && m_pend == 0)) begin
      cycle();
      c++;
      if (bus.RefBusy === 1'b1 && prev_busy !== 1'b1) refreshes++;
      prev_busy = bus.RefBusy;
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL saturate_drain c%0d: got %b/p%0d want %b/p%0d", c, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
      if (c >= 100) begin
        n_total++;
        $display("FAIL saturate_timeout: got pend %0d after %0d cycles want 0", m_pend, c);
        break;
      end
    end
    n_total++;
    if (refreshes < 3) $display("FAIL saturate_refreshes: got %0d want >=3", refreshes);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c;
    int ready_at;
    drive_idle();
    c = 0;
    while (m_cur.o !== V_RRAS && c < 40) begin
      cycle();
      c++;
    end
    n_total++;
    if (m_cur.o !== V_RRAS || bus.RefBusy !== 1'b1) begin
      $display("FAIL reset_mid_setup: got busy=%b after %0d cycles want refresh in RRAS", bus.RefBusy, c);
    end else begin
      n_pass++;
      #2 nRES = 1'b0;
      #1;
      n_total++;
      if (bus.nRAS !== 1'b1 || bus.nCAS !== 1'b1 || bus.RefBusy !== 1'b0 || bus.dbg_pending !== 2'd0)
        $display("FAIL reset_mid_async: got nRAS=%b nCAS=%b busy=%b p%0d want 1 1 0 p0",
                 bus.nRAS, bus.nCAS, bus.RefBusy, bus.dbg_pending);
      else n_pass++;
    end
    nRES = 1'b0;
    cycle();
    model_reset();
    nRES = 1'b1;
    ready_at = -1;
    bus.ASActive = 1'b1; bus.RAMCS = 1'b1; bus.nWE = 1'b1; bus.ASInactive = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      bus.ASActive = 1'b0;
      if (bus.RAMReady === 1'b1 && ready_at < 0) ready_at = k;
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL reset_mid_access c%0d: got %b/p%0d want %b/p%0d", k, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
    end
    n_total++;
    if (ready_at !== 2) $display("FAIL reset_mid_latency: got %0d want 2", ready_at);
    else n_pass++;
    drive_idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      bus.ASActive   = ($urandom_range(0, 3) == 0);
      bus.RAMCS      = ($urandom_range(0, 2) != 0);
      bus.ASInactive = ($urandom_range(0, 2) != 0);
      bus.nWE        = $urandom_range(0, 1) != 0;
      bus.nUDS       = $urandom_range(0, 1) != 0;
      bus.nLDS       = $urandom_range(0, 1) != 0;
      cycle();
      n_total++;
      if (dut_vec() !== m_cur.o || bus.dbg_pending !== 2'(m_pend))
        $display("FAIL random c%0d: got %b/p%0d want %b/p%0d", k, dut_vec(), bus.dbg_pending, m_cur.o, m_pend);
      else n_pass++;
    end
    drive_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read();
    test_write();
    test_refresh_idle();
    test_urgent();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
